// File: rtl/lif_spike_encoder_pkg.sv
// Shared constants for the LIF spike encoder: the default timestep count, the FSM
// state codes and a width helper.
`ifndef TIME_STEPS
`define TIME_STEPS 4
`endif

package lif_spike_encoder_pkg;

  localparam int TIME_STEPS_DEF = `TIME_STEPS;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // Counter width for n states, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lif_spike_encoder_lane.sv
// One leaky integrate-and-fire neuron: the membrane register, the leak update with
// saturation, the threshold compare and the post-spike reset.
module lif_neuron_lane #(
  parameter int ACC_W       = 12,
  parameter int V_TH        = 16,
  parameter int DECAY_SHIFT = 1,
  parameter int RESET_MODE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [ACC_W-1:0] x,
  output logic             spike
);

  localparam int W  = ACC_W + 2;
  localparam int W1 = W + 1;
  localparam logic signed [W:0]   H_MAX = W1'((1 << (W - 1)) - 1);
  localparam logic signed [W-1:0] VTH_S = W'(V_TH);

  logic signed [W-1:0] v;
  logic signed [W-1:0] xs;
  logic signed [W-1:0] diff;
  logic signed [W-1:0] sh;
  logic signed [W-1:0] h;
  logic signed [W:0]   sum;

  // The sum is formed one bit wider so it can be clamped instead of wrapping.
  always_comb begin
    xs    = signed'({2'b00, x});
    diff  = xs - v;
    sh    = diff >>> DECAY_SHIFT;
    sum   = {v[W-1], v} + {sh[W-1], sh};
    h     = (sum > H_MAX) ? H_MAX[W-1:0] : sum[W-1:0];
    spike = (h >= VTH_S);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
    end else if (clear) begin
      v <= '0;
    end else if (en) begin
      if (spike) v <= (RESET_MODE != 0) ? (h - VTH_S) : '0;
      else       v <= h;
    end
  end

endmodule

// File: rtl/lif_spike_encoder.sv
// LIF spike encoder top: accepts a beat of CH x TIME_STEPS accumulated inputs,
// steps the neuron lanes through the timesteps and presents the spike map downstream.
module lif_spike_encoder
  import lif_spike_encoder_pkg::*;
#(
  parameter int CH          = 8,
  parameter int TIME_STEPS  = TIME_STEPS_DEF,
  parameter int ACC_W       = 12,
  parameter int V_TH        = 16,
  parameter int DECAY_SHIFT = 1,
  parameter int RESET_MODE  = 0,
  parameter int N_BEATS     = 3072
) (
  input  logic                           s_clk,
  input  logic                           s_rst,
  input  logic [CH*TIME_STEPS*ACC_W-1:0] i_acc,
  input  logic                           i_acc_valid,
  output logic                           o_acc_ready,
  output logic [CH*TIME_STEPS-1:0]       o_spikes,
  output logic                           o_spikes_valid,
  input  logic                           i_spikes_ready,
  output logic                           o_frame_done
);

  localparam int TS_W  = width_of(TIME_STEPS);
  localparam int CNT_W = width_of(N_BEATS);

  logic [1:0]                     state;
  logic [TS_W-1:0]                t_cnt;
  logic [CH*TIME_STEPS*ACC_W-1:0] acc_q;
  logic [CH*TIME_STEPS-1:0]       spikes_q;
  logic                           spikes_valid_q;
  logic [CNT_W-1:0]               beat_cnt;
  logic [CH-1:0]                  lane_spike;
  logic                           in_xfer;
  logic                           out_xfer;
  logic                           run;
  logic                           last_t;

  // Ready is masked by reset so nothing is accepted while the block is held.
  assign o_acc_ready = ~s_rst & ((state == ST_IDLE) |
                                 ((state == ST_HOLD) & i_spikes_ready));
  assign in_xfer  = i_acc_valid & o_acc_ready;
  assign out_xfer = spikes_valid_q & i_spikes_ready;
  assign run      = (state == ST_RUN);
  assign last_t   = (t_cnt == TS_W'(TIME_STEPS - 1));

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      state          <= ST_IDLE;
      t_cnt          <= '0;
      acc_q          <= '0;
      spikes_valid_q <= 1'b0;
      beat_cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_xfer) begin
            state <= ST_RUN;
            t_cnt <= '0;
          end
        end
        ST_RUN: begin
          if (last_t) begin
            state          <= ST_HOLD;
            spikes_valid_q <= 1'b1;
          end else begin
            t_cnt <= t_cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          if (out_xfer) begin
            spikes_valid_q <= 1'b0;
            state          <= in_xfer ? ST_RUN : ST_IDLE;
            t_cnt          <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (in_xfer) acc_q <= i_acc;
      if (out_xfer)
        beat_cnt <= (beat_cnt == CNT_W'(N_BEATS - 1)) ? '0 : beat_cnt + 1'b1;
    end
  end

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      spikes_q <= '0;
    end else if (run) begin
      for (int unsigned c = 0; c < CH; c++)
        for (int unsigned t = 0; t < TIME_STEPS; t++)
          if (t_cnt == TS_W'(t)) spikes_q[TIME_STEPS*c + t] <= lane_spike[c];
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_lane
    logic [ACC_W-1:0] x_sel;

    always_comb x_sel = acc_q[ACC_W*(TIME_STEPS*c + t_cnt) +: ACC_W];

    lif_neuron_lane #(
      .ACC_W       (ACC_W),
      .V_TH        (V_TH),
      .DECAY_SHIFT (DECAY_SHIFT),
      .RESET_MODE  (RESET_MODE)
    ) u_lane (
      .clk   (s_clk),
      .rst   (s_rst),
      .clear (in_xfer),
      .en    (run),
      .x     (x_sel),
      .spike (lane_spike[c])
    );
  end

  assign o_spikes       = spikes_q;
  assign o_spikes_valid = spikes_valid_q;
  assign o_frame_done   = spikes_valid_q & (beat_cnt == CNT_W'(N_BEATS - 1));

endmodule

// File: tb/tb_lif_spike_encoder.sv
// Directed bench: a default encoder (hard reset) and a soft-reset encoder with a
// three-beat frame run side by side on the same stimulus.
module tb_lif_spike_encoder;

  localparam int CH = 8;
  localparam int TS = 4;
  localparam int AW = 12;

  logic              clk;
  logic              rst;
  logic [CH*TS*AW-1:0] acc;
  logic              acc_valid;
  logic              spikes_ready;

  logic              a_acc_ready, b_acc_ready;
  logic [CH*TS-1:0]  a_spikes, b_spikes;
  logic              a_spikes_valid, b_spikes_valid;
  logic              a_frame_done, b_frame_done;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] trace [0:31];

  lif_spike_encoder dut_a (
    .s_clk          (clk),
    .s_rst          (rst),
    .i_acc          (acc),
    .i_acc_valid    (acc_valid),
    .o_acc_ready    (a_acc_ready),
    .o_spikes       (a_spikes),
    .o_spikes_valid (a_spikes_valid),
    .i_spikes_ready (spikes_ready),
    .o_frame_done   (a_frame_done)
  );

  lif_spike_encoder #(
    .RESET_MODE (1),
    .N_BEATS    (3)
  ) dut_b (
    .s_clk          (clk),
    .s_rst          (rst),
    .i_acc          (acc),
    .i_acc_valid    (acc_valid),
    .o_acc_ready    (b_acc_ready),
    .o_spikes       (b_spikes),
    .o_spikes_valid (b_spikes_valid),
    .i_spikes_ready (spikes_ready),
    .o_frame_done   (b_frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CH*TS*AW-1:0] mk_acc(input bit all_ch, input int x0,
                                                 input int x1, input int x2, input int x3);
    logic [CH*TS*AW-1:0] r;
    int xs [4];
    xs = '{x0, x1, x2, x3};
    r = '0;
    for (int c = 0; c < CH; c++)
      for (int t = 0; t < TS; t++)
        if (all_ch || c == 0) r[AW*(TS*c+t) +: AW] = AW'(xs[t]);
    return r;
  endfunction

  task automatic put_beat(input logic [CH*TS*AW-1:0] a);
    int w = 0;
    while (!a_acc_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("put_ready", a_acc_ready, 1);
    acc = a;
    acc_valid = 1'b1;
    @(negedge clk);
    acc_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 1;
    trace[1] = dut_b.g_lane[0].u_lane.v;
    while (!a_spikes_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      trace[lat] = dut_b.g_lane[0].u_lane.v;
    end
  endtask

  task automatic take();
    spikes_ready = 1'b1;
    @(negedge clk);
    spikes_ready = 1'b0;
  endtask

  task automatic run_beat(input string tag, input logic [CH*TS*AW-1:0] a,
                          input logic [31:0] exp_a, input logic [31:0] exp_b);
    int lat;
    put_beat(a);
    wait_result(lat);
    check({tag, "_lat"}, lat, 5);
    check({tag, "_a"}, a_spikes, exp_a);
    check({tag, "_b"}, b_spikes, exp_b);
    check({tag, "_bvalid"}, b_spikes_valid, 1);
    take();
    check({tag, "_drop"}, a_spikes_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int lat, beats, cyc, last, seen;
    rst = 1'b1;
    acc = '0;
    acc_valid = 1'b0;
    spikes_ready = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", a_acc_ready, 0);
    check("rst_valid", a_spikes_valid, 0);
    check("rst_spikes", a_spikes, 0);
    check("rst_fdone", a_frame_done, 0);
    rst = 1'b0;
    #1;
    check("rst_release_ready", a_acc_ready, 1);
    @(negedge clk);

    // Single-channel pulse; soft-reset membrane trace 4,2,1,0
    put_beat(mk_acc(0, 40, 0, 0, 0));
    wait_result(lat);
    check("pulse_lat", lat, 5);
    check("pulse_a", a_spikes, 32'h1);
    check("pulse_b", b_spikes, 32'h1);
    check("trace_t0", trace[2], 4);
    check("trace_t1", trace[3], 2);
    check("trace_t2", trace[4], 1);
    check("trace_t3", trace[5], 0);
    take();

    // Sustained input, threshold edges, mode divergence, large input
    run_beat("x32",    mk_acc(1, 32, 32, 32, 32), 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_beat("x32alt", mk_acc(1, 32, 0, 32, 0),   32'h55555555, 32'h55555555);
    run_beat("th_eq",  mk_acc(1, 32, 0, 0, 0),    32'h11111111, 32'h11111111);
    run_beat("th_lo",  mk_acc(1, 31, 0, 0, 0),    32'h00000000, 32'h00000000);
    run_beat("mode",   mk_acc(1, 64, 16, 0, 0),   32'h11111111, 32'h33333333);
    run_beat("big",    mk_acc(1, 4095, 4095, 4095, 4095), 32'hFFFFFFFF, 32'hFFFFFFFF);

    // Backpressure for 20 cycles with a competing beat offered
    put_beat(mk_acc(1, 32, 32, 32, 32));
    wait_result(lat);
    check("bp_lat", lat, 5);
    acc = mk_acc(1, 64, 16, 0, 0);
    acc_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_spikes", a_spikes, 32'hFFFFFFFF);
      check("bp_ready", a_acc_ready, 0);
      check("bp_valid", a_spikes_valid, 1);
    end
    acc_valid = 1'b0;
    take();
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (a_spikes_valid) seen++;
    end
    check("bp_no_extra", seen, 0);
    run_beat("bp_next", mk_acc(1, 64, 16, 0, 0), 32'h11111111, 32'h33333333);

    // Frame of three beats, seven streamed back to back
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    acc = mk_acc(1, 32, 0, 32, 0);
    acc_valid = 1'b1;
    spikes_ready = 1'b1;
    beats = 0;
    cyc = 0;
    last = 0;
    while (beats < 7 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (b_spikes_valid) begin
        beats++;
        check("frame_done_b", b_frame_done, (beats == 3 || beats == 6));
        check("frame_done_a", a_frame_done, 0);
        check("frame_spikes", b_spikes, 32'h55555555);
        if (beats > 1) check("frame_period", cyc - last, 5);
        last = cyc;
        if (beats == 7) acc_valid = 1'b0;
      end
    end
    check("frame_beats", beats, 7);
    @(negedge clk);
    spikes_ready = 1'b0;
    check("frame_wrap_cnt", dut_b.beat_cnt, 1);

    // Reset during RUN cycle 2
    put_beat(mk_acc(1, 32, 32, 32, 32));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_a_spikes", a_spikes, 0);
    check("mid_a_valid", a_spikes_valid, 0);
    check("mid_a_ready", a_acc_ready, 0);
    check("mid_b_spikes", b_spikes, 0);
    check("mid_b_fdone", b_frame_done, 0);
    check("mid_membrane", dut_b.g_lane[0].u_lane.v, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_release_ready", a_acc_ready, 1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (a_spikes_valid || b_spikes_valid) seen++;
    end
    check("mid_no_stale", seen, 0);
    run_beat("after_rst", mk_acc(1, 64, 16, 0, 0), 32'h11111111, 32'h33333333);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
